sdram_bus_tap: RTL

SDRAM_BUS_TAP -- requirements
Module: sdram_bus_tap

---
 rtl/sdram_bus_tap.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sdram_bus_tap.sv
// sdram_bus_tap
//   Passive tap on an SDRAM controller's command/address/data pins. Samples the
//   pins, decodes the command, and feeds a logic analyzer with aligned data,
//   command and a one-shot trigger. It also tracks which row is open in each
//   bank and counts non-NOP commands.
//
// Ports
//   sys_clk, sys_rst          clock and async active-high reset
//   sdram_*                   controller pins being observed (inputs only)
//   arm                       one-cycle pulse that arms the trigger
//   trig_cmd/ba/addr/mask     trigger compare value and address care mask
//   cnt_clr                   synchronous clear of cmd_count
//   probe_data                {dq, ba, dqm, addr[12:0]}, two cycles after the pins
//   probe_cmd                 decoded command aligned with probe_data
//   trig_o                    one-cycle trigger pulse aligned with probe_data
//   armed                     trigger armed status
//   open_valid, open_row      per-bank open flag and open row (bank b at b*ROW_W)
//   cmd_count                 saturating count of non-NOP commands
module sdram_bus_tap #(
    parameter int ROW_W = 13,
    parameter int CNT_W = 16
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               sdram_cs_n,
    input  logic               sdram_ras_n,
    input  logic               sdram_cas_n,
    input  logic               sdram_we_n,
    input  logic [1:0]         sdram_ba,
    input  logic [1:0]         sdram_dqm,
    input  logic [ROW_W-1:0]   sdram_addr,
    input  logic [15:0]        sdram_dq_i,
    input  logic               arm,
    input  logic [2:0]         trig_cmd,
    input  logic [1:0]         trig_ba,
    input  logic [ROW_W-1:0]   trig_addr,
    input  logic [ROW_W-1:0]   trig_mask,
    input  logic               cnt_clr,
    output logic [32:0]        probe_data,
    output logic [2:0]         probe_cmd,
    output logic               trig_o,
    output logic               armed,
    output logic [3:0]         open_valid,
    output logic [4*ROW_W-1:0] open_row,
    output logic [CNT_W-1:0]   cmd_count
);

    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_PRE = 3'b010;

    logic               r_s1_cs_n;
    logic               r_s1_ras_n;
    logic               r_s1_cas_n;
    logic               r_s1_we_n;
    logic [1:0]         r_s1_ba;
    logic [1:0]         r_s1_dqm;
    logic [ROW_W-1:0]   r_s1_addr;
    logic [15:0]        r_s1_dq;

    logic [2:0]         w_cmd;
    logic               w_match;
    logic [12:0]        w_addr13;

    // Stage 1: raw pin capture. The strobes reset to their inactive (high)
    // level so the cleared stage decodes as NOP rather than MRS.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_s1_cs_n  <= 1'b1;
            r_s1_ras_n <= 1'b1;
            r_s1_cas_n <= 1'b1;
            r_s1_we_n  <= 1'b1;
            r_s1_ba    <= '0;
            r_s1_dqm   <= '0;
            r_s1_addr  <= '0;
            r_s1_dq    <= '0;
        end else begin
            r_s1_cs_n  <= sdram_cs_n;
            r_s1_ras_n <= sdram_ras_n;
            r_s1_cas_n <= sdram_cas_n;
            r_s1_we_n  <= sdram_we_n;
            r_s1_ba    <= sdram_ba;
            r_s1_dqm   <= sdram_dqm;
            r_s1_addr  <= sdram_addr;
            r_s1_dq    <= sdram_dq_i;
        end
    end

    assign w_cmd    = r_s1_cs_n ? CMD_NOP : {r_s1_ras_n, r_s1_cas_n, r_s1_we_n};
    assign w_addr13 = 13'(r_s1_addr);
    // Trigger config is used live, so a change applies to the next command in stage 1.
    assign w_match  = (w_cmd == trig_cmd) && (r_s1_ba == trig_ba) &&
                      (((r_s1_addr ^ trig_addr) & trig_mask) == '0);

    // Stage 2: every output is registered here from stage 1.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            probe_data <= '0;
            probe_cmd  <= CMD_NOP;
            trig_o     <= 1'b0;
            armed      <= 1'b0;
            open_valid <= '0;
            open_row   <= '0;
            cmd_count  <= '0;
        end else begin
            probe_data <= {r_s1_dq, r_s1_ba, r_s1_dqm, w_addr13};
            probe_cmd  <= w_cmd;
            trig_o     <= armed && w_match;

            // A fresh arm pulse re-arms even while the current match fires.
            if (arm)
                armed <= 1'b1;
            else if (armed && w_match)
                armed <= 1'b0;

            // Closing a bank only drops its valid flag; the last row stays visible.
            if (w_cmd == CMD_ACT) begin
                for (int b = 0; b < 4; b++) begin
                    if (r_s1_ba == b[1:0]) begin
                        open_valid[b]                <= 1'b1;
                        open_row[b*ROW_W +: ROW_W]   <= r_s1_addr;
                    end
                end
            end else if (w_cmd == CMD_PRE) begin
                if (r_s1_addr[10])
                    open_valid <= '0;
                else
                    open_valid[r_s1_ba] <= 1'b0;
            end

            // cnt_clr discards the command sitting in stage 1 this cycle.
            if (cnt_clr)
                cmd_count <= '0;
            else if ((w_cmd != CMD_NOP) && (cmd_count != '1))
                cmd_count <= cmd_count + CNT_W'(1);
        end
    end

endmodule
